// File: rtl/slu_pkg.sv
// Shared types and constants for the sum/latch/UART transmit engine.
package slu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic UART_IDLE = 1'b1;
   localparam int   BIT_IDX_W = 3;

endpackage

// File: rtl/sum_latch_uart_tx_uart_tx_byte.sv
// Single-byte UART transmitter with valid/ready load handshake; back-to-back bytes chain STOP -> START.
// Optional even-parity bit is enabled by defining SLU_PARITY_EN.
module uart_tx_byte
   import slu_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       txd,
   output logic       busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   state_t               state, state_nx;
   logic [CNT_W-1:0]     cnt, cnt_nx;
   logic [BIT_IDX_W-1:0] bit_idx, bit_idx_nx;
   logic [7:0]           shreg, shreg_nx;
   logic                 tick, load;
`ifdef SLU_PARITY_EN
   logic                 par, par_nx;
`endif

   assign tick       = (cnt == CNT_W'(CLKS_PER_BIT - 1));
   // A new byte is taken while idle or on the final cycle of STOP, so bytes chain without a gap.
   assign byte_ready = (state == IDLE) || ((state == STOP) && tick);
   assign load       = byte_valid && byte_ready;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
`ifdef SLU_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         bit_idx <= bit_idx_nx;
         shreg   <= shreg_nx;
`ifdef SLU_PARITY_EN
         par     <= par_nx;
`endif
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = ((state == IDLE) || tick) ? '0 : cnt + CNT_W'(1);
      bit_idx_nx = bit_idx;
      shreg_nx   = shreg;
`ifdef SLU_PARITY_EN
      par_nx     = par;
`endif
      case (state)
         IDLE:  if (byte_valid) state_nx = START;
         START: if (tick) begin
            state_nx   = DATA;
            bit_idx_nx = '0;
         end
         DATA:  if (tick) begin
            shreg_nx   = shreg >> 1;
            bit_idx_nx = bit_idx + BIT_IDX_W'(1);
`ifdef SLU_PARITY_EN
            if (&bit_idx) state_nx = PARITY;
`else
            if (&bit_idx) state_nx = STOP;
`endif
         end
`ifdef SLU_PARITY_EN
         PARITY: if (tick) state_nx = STOP;
`endif
         STOP:  if (tick) state_nx = byte_valid ? START : IDLE;
         default: state_nx = IDLE;
      endcase
      if (load) begin
         shreg_nx = byte_data;
`ifdef SLU_PARITY_EN
         par_nx   = ^byte_data;
`endif
      end
   end

   always_comb begin
      txd = UART_IDLE;
      case (state)
         START: txd = ~UART_IDLE;
         DATA:  txd = shreg[0];
`ifdef SLU_PARITY_EN
         PARITY: txd = par;
`endif
         default: txd = UART_IDLE;
      endcase
   end

endmodule

// File: rtl/sum_latch_uart_tx.sv
// Operand latch + adder + multi-byte UART sender; sum goes out LSB byte first once every operand is saved.
// Define SLU_PARITY_EN for 8E1 framing instead of 8N1.
module sum_latch_uart_tx
   import slu_pkg::*;
#(
   parameter  int DATA_W       = 4,
   parameter  int NUM_OPS      = 2,
   parameter  int CLKS_PER_BIT = 5208,
   localparam int SUM_W        = DATA_W + $clog2(NUM_OPS)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_OPS-1:0] save_n,
   input  logic [DATA_W-1:0]  data_in,
   output logic [NUM_OPS-1:0] op_valid,
   output logic [SUM_W-1:0]   sum_out,
   output logic               uart_txd,
   output logic               uart_tx_busy
);

   localparam int NBYTES = (SUM_W + 7) / 8;
   localparam int BUF_W  = NBYTES * 8;
   localparam int LEFT_W = $clog2(NBYTES + 1);

   logic [NUM_OPS-1:0] sync_p0, sync_p1, save_prev, fall;
   logic [DATA_W-1:0]  ops [NUM_OPS];
   logic [SUM_W-1:0]   sum_c;
   logic [BUF_W-1:0]   sum_pad, byte_buf;
   logic [LEFT_W-1:0]  bytes_left;
   logic               trigger, byte_valid, byte_ready;
   logic [7:0]         byte_data;

   // Synchronise the push-button strobes; idle level is high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_p0   <= '1;
         sync_p1   <= '1;
         save_prev <= '1;
      end else begin
         sync_p0   <= save_n;
         sync_p1   <= sync_p0;
         save_prev <= sync_p1;
      end
   end

   assign fall = save_prev & ~sync_p1;

   // Snapshot uses the live operand sum: sum_out lags operand updates by one cycle.
   assign trigger = !uart_tx_busy && (&op_valid);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_OPS; i++) ops[i] <= '0;
         op_valid <= '0;
      end else begin
         for (int i = 0; i < NUM_OPS; i++) begin
            if (fall[i]) ops[i] <= data_in;
         end
         op_valid <= trigger ? fall : (op_valid | fall);
      end
   end

   always_comb begin
      sum_c = '0;
      for (int i = 0; i < NUM_OPS; i++) sum_c = sum_c + SUM_W'(ops[i]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sum_out <= '0;
      else          sum_out <= sum_c;
   end

   // Byte sequencer: first byte comes straight from the sum, the rest from the shifted buffer.
   assign sum_pad    = BUF_W'(sum_c);
   assign byte_valid = trigger || (bytes_left != '0);
   assign byte_data  = trigger ? sum_pad[7:0] : byte_buf[7:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         byte_buf   <= '0;
         bytes_left <= '0;
      end else if (byte_valid && byte_ready) begin
         if (trigger) begin
            byte_buf   <= sum_pad >> 8;
            bytes_left <= LEFT_W'(NBYTES - 1);
         end else begin
            byte_buf   <= byte_buf >> 8;
            bytes_left <= bytes_left - LEFT_W'(1);
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk       (clk),
      .reset_n   (reset_n),
      .byte_data (byte_data),
      .byte_valid(byte_valid),
      .byte_ready(byte_ready),
      .txd       (uart_txd),
      .busy      (uart_tx_busy)
   );

endmodule

// File: tb/tb_sum_latch_uart_tx.sv
// Directed bench for sum_latch_uart_tx: a 4-bit/2-operand instance and an 8-bit/4-operand instance.
module tb_sum_latch_uart_tx;

`ifdef SLU_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] save0;
   logic [3:0] data0;
   logic [1:0] ov0;
   logic [4:0] sum0;
   logic       txd0, busy0;
   logic [3:0] save1;
   logic [7:0] data1;
   logic [3:0] ov1;
   logic [9:0] sum1;
   logic       txd1, busy1;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic samp [0:255];
   int   busy_len;

   always #5 clk = ~clk;

   sum_latch_uart_tx #(.DATA_W(4), .NUM_OPS(2), .CLKS_PER_BIT(CPB)) u0 (
      .clk(clk), .reset_n(reset_n), .save_n(save0), .data_in(data0),
      .op_valid(ov0), .sum_out(sum0), .uart_txd(txd0), .uart_tx_busy(busy0));

   sum_latch_uart_tx #(.DATA_W(8), .NUM_OPS(4), .CLKS_PER_BIT(CPB)) u1 (
      .clk(clk), .reset_n(reset_n), .save_n(save1), .data_in(data1),
      .op_valid(ov1), .sum_out(sum1), .uart_txd(txd1), .uart_tx_busy(busy1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic cur_busy(input int sel);
      return (sel == 0) ? busy0 : busy1;
   endfunction

   // One-cycle low pulse on save_n; returns on the negedge just after the operand latches.
   task automatic save(input int sel, input int idx, input logic [7:0] v);
      @(negedge clk);
      if (sel == 0) begin data0 = v[3:0]; save0[idx] = 1'b0; end
      else          begin data1 = v;      save1[idx] = 1'b0; end
      @(negedge clk);
      if (sel == 0) save0[idx] = 1'b1;
      else          save1[idx] = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // Waits for busy, then records txd every negedge while busy stays high.
   task automatic capture(input int sel, input string tag);
      int w = 0;
      busy_len = 0;
      while (cur_busy(sel) !== 1'b1 && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (w >= 300) begin
         chk({tag, "_start_timeout"}, 32'd0, 32'd1);
         return;
      end
      while (cur_busy(sel) === 1'b1 && busy_len < 256) begin
         samp[busy_len] = (sel == 0) ? txd0 : txd1;
         busy_len++;
         @(negedge clk);
      end
   endtask

   // Serial bits of byte k, bit 0 = start bit, sampled in the second cycle of each bit period.
   function automatic logic [10:0] got_frame(input int k);
      logic [10:0] r = '0;
      for (int j = 0; j < FB; j++) r[j] = samp[k*FB*CPB + j*CPB + 1];
      return r;
   endfunction

   function automatic logic [10:0] model_frame(input logic [7:0] b);
`ifdef SLU_PARITY_EN
      return {1'b1, ^b, b, 1'b0};
`else
      return {1'b0, 1'b1, b, 1'b0};
`endif
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      int w;
      reset_n = 1'b0;
      save0 = '1; save1 = '1;
      data0 = '0; data1 = '0;
      repeat (3) @(negedge clk);
      chk("rst_txd0", txd0, 1);
      chk("rst_busy0", busy0, 0);
      chk("rst_ov0", ov0, 0);
      chk("rst_sum0", sum0, 0);
      chk("rst_txd1", txd1, 1);
      chk("rst_sum1", sum1, 0);
      reset_n = 1'b1;

      // A=9, B=12 -> 0x15
      save(0, 0, 8'd9);
      chk("s1_ov_a", ov0, 2'b01);
      save(0, 1, 8'd12);
      capture(0, "s1");
      chk("s1_sum", sum0, 21);
`ifdef SLU_PARITY_EN
      chk("s1_bits", got_frame(0), 11'h62A);
`else
      chk("s1_bits", got_frame(0), 11'h22A);
`endif
      chk("s1_busy_len", busy_len, FB*CPB);
      chk("s1_ov_clr", ov0, 0);

      // Re-save A without B: no frame
      save(0, 0, 8'd3);
      save(0, 0, 8'd5);
      chk("s2_ov", ov0, 2'b01);
      seen = 0;
      repeat (200) begin
         @(negedge clk);
         if (busy0) seen++;
      end
      chk("s2_no_frame", seen, 0);
      chk("s2_ov_hold", ov0, 2'b01);
      chk("s2_sum_partial", sum0, 17);
      save(0, 1, 8'd1);
      capture(0, "s2");
      chk("s2_frame", got_frame(0), model_frame(8'h06));
      chk("s2_sum", sum0, 6);

      // Wide instance: 4 x 255 -> 0x3FC, two bytes back-to-back
      for (int i = 0; i < 4; i++) save(1, i, 8'd255);
      capture(1, "s3");
      chk("s3_sum", sum1, 10'h3FC);
      chk("s3_byte0", got_frame(0), model_frame(8'hFC));
      chk("s3_byte1", got_frame(1), model_frame(8'h03));
      chk("s3_busy_len", busy_len, 2*FB*CPB);
      chk("s3_ov_clr", ov1, 0);

`ifdef SLU_PARITY_EN
      save(0, 0, 8'd15);
      save(0, 1, 8'd15);
      capture(0, "s5a");
      chk("s5_frame_1e", got_frame(0), 11'h43C);
      chk("s5_busy_len", busy_len, 11*CPB);
      save(0, 0, 8'd9);
      save(0, 1, 8'd12);
      capture(0, "s5b");
      chk("s5_parity_15", samp[9*CPB + 1], 1);
`endif

      // Saves during a frame: queued for the next frame
      save(0, 0, 8'd10);
      save(0, 1, 8'd11);
      fork
         capture(0, "s6a");
         begin
            repeat (6) @(negedge clk);
            save(0, 0, 8'd1);
            save(0, 1, 8'd2);
         end
      join
      chk("s6_first", got_frame(0), model_frame(8'h15));
      chk("s6_ov_pending", ov0, 2'b11);
      @(negedge clk);
      chk("s6_restart", busy0, 1);
      capture(0, "s6b");
      chk("s6_second", got_frame(0), model_frame(8'h03));
      chk("s6_ov_clr", ov0, 0);

      // Reset in the middle of a frame
      save(0, 0, 8'd7);
      save(0, 1, 8'd8);
      w = 0;
      while (busy0 !== 1'b1 && w < 300) begin
         @(negedge clk);
         w++;
      end
      repeat (17) @(negedge clk);
      chk("s4_busy_before", busy0, 1);
      reset_n = 1'b0;
      #1;
      chk("s4_txd", txd0, 1);
      chk("s4_busy", busy0, 0);
      chk("s4_ov", ov0, 0);
      @(negedge clk);
      reset_n = 1'b1;
      save(0, 0, 8'd2);
      save(0, 1, 8'd4);
      capture(0, "s4");
      chk("s4_frame", got_frame(0), model_frame(8'h06));
      chk("s4_busy_len", busy_len, FB*CPB);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
